// File: rtl/mult_seq_pkg.sv
// Shared definitions for the mult_seq iterative multiplier: the FSM state
// encoding, the product-width rule and the counter-width helper.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Product width: low N bits when truncating, otherwise the full N+M bits.
  function automatic int calc_ow(input int n, input int m, input int full);
    return (full != 0) ? n + m : n;
  endfunction

  // Smallest r with 2**r >= value; used for the iteration counter width.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_seq_add.sv
// ADD: library ripple-carry adder, S = A + B + CI with carry out CO.
module ADD #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CI,
  output logic [N-1:0] S,
  output logic         CO
);

  logic [N:0] carry;

  assign carry[0] = CI;

  // One full-adder cell per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign S[i]         = A[i] ^ B[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign CO = carry[N];

endmodule

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add unsigned multiplier, one multiplier bit per
// cycle, with valid/ready handshakes on operands and product.
// Optional build macro MULT_SEQ_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero. Left undefined, every operation takes exactly
// M RUN cycles (constant time).
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = N,
  parameter int FULL = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0]                     A,
  input  logic [M-1:0]                     B,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [calc_ow(N, M, FULL)-1:0]   O
);

  localparam int OW = calc_ow(N, M, FULL);
  localparam int CW = clog2_f(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  state_e          state_q, state_d;
  logic [OW-1:0]   a_sh_q, a_sh_d;
  logic [M-1:0]    b_sh_q, b_sh_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [OW-1:0]   addend;
  logic [OW-1:0]   sum;
  logic            add_co_unused;

  // Partial product for this iteration: the shifted multiplicand or zero.
  assign addend = b_sh_q[0] ? a_sh_q : '0;

  ADD #(
    .N (OW)
  ) u_add (
    .A  (acc_q),
    .B  (addend),
    .CI (1'b0),
    .S  (sum),
    .CO (add_co_unused)
  );

  // Next-state and datapath update for IDLE / RUN / DONE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = OW'(A);
          b_sh_d  = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if ((cnt_q == CNT_LAST) || (b_sh_d == '0)) state_d = ST_DONE;
`else
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: datapath registers are reset too, so O reads zero after reset
      // and no stale product survives an aborted operation.
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign O         = acc_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: four configurations run side by side
// (8x8 truncated, 8x8 full, 16x4 full, 16x4 truncated) from shared stimulus.
module tb_mult_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_ready;

  logic        ir_8t, ir_8f, ir_16f, ir_16t;
  logic        ov_8t, ov_8f, ov_16f, ov_16t;
  logic [7:0]  o_8t;
  logic [15:0] o_8f;
  logic [19:0] o_16f;
  logic [15:0] o_16t;

  logic [3:0]  ov_all;
  logic [3:0]  ir_all;
  assign ov_all = {ov_16t, ov_16f, ov_8f, ov_8t};
  assign ir_all = {ir_16t, ir_16f, ir_8f, ir_8t};

  int errors = 0;
  int checks = 0;
  int lat [4];

  mult_seq #(.N(8), .M(8), .FULL(0)) u_d8t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_8t),
    .A(A[7:0]), .B(B[7:0]), .out_valid(ov_8t), .out_ready(out_ready), .O(o_8t));

  mult_seq #(.N(8), .M(8), .FULL(1)) u_d8f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_8f),
    .A(A[7:0]), .B(B[7:0]), .out_valid(ov_8f), .out_ready(out_ready), .O(o_8f));

  mult_seq #(.N(16), .M(4), .FULL(1)) u_d16f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_16f),
    .A(A), .B(B[3:0]), .out_valid(ov_16f), .out_ready(out_ready), .O(o_16f));

  mult_seq #(.N(16), .M(4), .FULL(0)) u_d16t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_16t),
    .A(A), .B(B[3:0]), .out_valid(ov_16t), .out_ready(out_ready), .O(o_16t));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  e8t;
    logic [15:0] e8f;
    logic [19:0] e16f;
    logic [15:0] e16t;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RUN-cycle count the bench expects for a multiplier value of width m.
  function automatic int exp_lat(input logic [7:0] b, input int m);
    int h;
    h = 0;
    for (int i = 0; i < m; i++) if (b[i]) h = i + 1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    return (h == 0) ? 1 : h;
`else
    return (h < 0) ? 0 : m;
`endif
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until each DUT raises out_valid (bounded).
  task automatic wait_done();
    for (int i = 0; i < 4; i++) lat[i] = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (lat[i] < 0 && ov_all[i]) lat[i] = c;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0 && lat[3] >= 0) break;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " in_ready after handshake"}, 32'(ir_all), 32'hF);
    check({tag, " out_valid after handshake"}, 32'(ov_all), 32'h0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h000F, 8'h11, 8'hFF, 16'h00FF, 20'h0000F, 16'h000F};
    vecs[1] = '{16'h00FF, 8'hFF, 8'h01, 16'hFE01, 20'h00EF1, 16'h0EF1};
    vecs[2] = '{16'h1234, 8'h0F, 8'h0C, 16'h030C, 20'h1110C, 16'h110C};
    vecs[3] = '{16'h0003, 8'h05, 8'h0F, 16'h000F, 20'h0000F, 16'h000F};
    vecs[4] = '{16'h0000, 8'hAB, 8'h00, 16'h0000, 20'h00000, 16'h0000};
    vecs[5] = '{16'hFFFF, 8'h00, 8'h00, 16'h0000, 20'h00000, 16'h0000};
    vecs[6] = '{16'h0081, 8'h80, 8'h80, 16'h4080, 20'h00000, 16'h0000};
    vecs[7] = '{16'hABCD, 8'h01, 8'hCD, 16'h00CD, 20'h0ABCD, 16'hABCD};
    vecs[8] = '{16'hFFFF, 8'hFF, 8'h01, 16'hFE01, 20'hEFFF1, 16'hFFF1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(ir_all), 32'hF);
    check("reset out_valid", 32'(ov_all), 32'h0);
    check("reset O 8t", 32'(o_8t), 32'h0);
    check("reset O 16f", 32'(o_16f), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven products and latencies.
    for (int v = 0; v < 9; v++) begin
      start_op(vecs[v].a, vecs[v].b);
      check($sformatf("v%0d in_ready during op", v), 32'(ir_all), 32'h0);
      wait_done();
      check($sformatf("v%0d latency 8t", v), 32'(lat[0]), 32'(exp_lat(vecs[v].b, 8)));
      check($sformatf("v%0d latency 8f", v), 32'(lat[1]), 32'(exp_lat(vecs[v].b, 8)));
      check($sformatf("v%0d latency 16f", v), 32'(lat[2]), 32'(exp_lat(vecs[v].b, 4)));
      check($sformatf("v%0d latency 16t", v), 32'(lat[3]), 32'(exp_lat(vecs[v].b, 4)));
      check($sformatf("v%0d O 8t", v), 32'(o_8t), 32'(vecs[v].e8t));
      check($sformatf("v%0d O 8f", v), 32'(o_8f), 32'(vecs[v].e8f));
      check($sformatf("v%0d O 16f", v), 32'(o_16f), 32'(vecs[v].e16f));
      check($sformatf("v%0d O 16t", v), 32'(o_16t), 32'(vecs[v].e16t));
      release_out($sformatf("v%0d", v));
    end

    // Backpressure: O held, in_ready low, in_valid pulses ignored.
    start_op(16'h000F, 8'h11);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      A        = 16'h5555;
      B        = 8'h33;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d O 8t held", i), 32'(o_8t), 32'hFF);
      check($sformatf("bp%0d O 16f held", i), 32'(o_16f), 32'h0000F);
      check($sformatf("bp%0d in_ready low", i), 32'(ir_all), 32'h0);
      check($sformatf("bp%0d out_valid high", i), 32'(ov_all), 32'hF);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("bp");

    // Reset during the third RUN cycle aborts the operation.
    start_op(16'h00FF, 8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun reset out_valid", 32'(ov_all), 32'h0);
    check("midrun reset in_ready", 32'(ir_all), 32'hF);
    check("midrun reset O 8t", 32'(o_8t), 32'h0);
    check("midrun reset O 8f", 32'(o_8f), 32'h0);
    check("midrun reset O 16f", 32'(o_16f), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    start_op(16'h0003, 8'h05);
    wait_done();
    check("post-reset O 8t", 32'(o_8t), 32'h0F);
    check("post-reset O 8f", 32'(o_8f), 32'h000F);
    check("post-reset O 16f", 32'(o_16f), 32'h0000F);
    check("post-reset O 16t", 32'(o_16t), 32'h000F);
    check("post-reset latency 8t", 32'(lat[0]), 32'(exp_lat(8'h05, 8)));
    release_out("post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
